// File: rtl/inv_key_expansion.sv
// inv_key_expansion: AES-128 inverse key schedule, walks round key 10 back to the cipher key (define INV_KEY_REG_OUT_EN for a registered read port)
module inv_key_expansion #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] final_key,
    input  logic [3:0]   desired_round,
    output logic [127:0] expanded_key,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] bank_q [0:NR];
    logic [127:0] bank_d [0:NR];
    logic [127:0] cur_q, cur_d, prev, rd;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon;
    logic [31:0]  p0, p1, p2, p3;
    logic         accept, last;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            r = b[i] ? r ^ x : r;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t, r;
        t = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // one backward step of the schedule from the current round key
    always_comb begin
        rcon = cnt_q == 4'd9 ? 8'h1b : cnt_q == 4'd10 ? 8'h36 : 8'h01 << (cnt_q - 4'd1);
        p3   = cur_q[31:0] ^ cur_q[63:32];
        p2   = cur_q[63:32] ^ cur_q[95:64];
        p1   = cur_q[95:64] ^ cur_q[127:96];
        p0   = cur_q[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon, 24'h0};
        prev = {p0, p1, p2, p3};
    end

    // next state: start is honoured only outside RUN, RUN ends on the last step
    always_comb begin
        accept  = start && state_q != RUN;
        last    = state_q == RUN && cnt_q == 4'd1;
        state_d = accept ? RUN : last ? DONE : state_q;
    end

    // bank, working key and round counter updates
    always_comb begin
        bank_d = bank_q;
        cur_d  = cur_q;
        cnt_d  = cnt_q;
        if (accept) begin
            bank_d[NR] = final_key;
            cur_d      = final_key;
            cnt_d      = 4'(NR);
        end else if (state_q == RUN) begin
            bank_d[cnt_q - 4'd1] = prev;
            cur_d                = prev;
            cnt_d                = cnt_q - 4'd1;
        end
    end

    // status outputs decoded from the state
    always_comb begin
        busy = state_q == RUN;
        done = state_q == DONE;
        rd   = desired_round <= 4'(NR) ? bank_q[desired_round] : '0;
    end

    // state and datapath registers; reset aborts any walk and zeroes the bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

`ifdef INV_KEY_REG_OUT_EN
    logic [127:0] expanded_key_q, expanded_key_d;

    // read port register, one cycle behind desired_round
    always_comb expanded_key_d = rd;

    // registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) expanded_key_q <= '0;
        else        expanded_key_q <= expanded_key_d;
    end

    assign expanded_key = expanded_key_q;
`else
    assign expanded_key = rd;
`endif

endmodule

// File: tb/tb_inv_key_expansion.sv
// tb_inv_key_expansion: vector, randomized and corner-sequence checks of the inverse key schedule
module tb_inv_key_expansion;

    logic         clk, reset, start, busy, done;
    logic [127:0] final_key, expanded_key;
    logic [3:0]   desired_round;
    int           tests, fails;
    logic [127:0] model_k [0:10];

    localparam logic [127:0] V1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] V2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [127:0] fk;
        int           rnd;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [5];

    inv_key_expansion #(.NR(10)) dut (
        .clk(clk), .reset(reset), .start(start), .final_key(final_key),
        .desired_round(desired_round), .expanded_key(expanded_key),
        .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 0, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = xt(x);
        end
        return r;
    endfunction

    // S-box from its definition: brute-force multiplicative inverse, then affine bit formula
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] b = 0, s;
        logic [7:0] c = 8'h63;
        for (int y = 1; y < 256; y++) if (mul(x, 8'(y)) == 8'h01) b = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return s;
    endfunction

    // word-array form of the schedule: w[i] = w[i+4] ^ t(w[i+3])
    task automatic model(input logic [127:0] fk);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int j = 0; j < 4; j++) w[40+j] = fk[127-32*j -: 32];
        for (int i = 39; i >= 0; i--) begin
            t = w[i+3];
            if (i % 4 == 0) begin
                rc = 8'h01;
                for (int k = 0; k < i/4; k++) rc = xt(rc);
                t = {t[23:0], t[31:24]};
                t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])} ^ {rc, 24'h0};
            end
            w[i] = w[i+4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic read(input int r, output logic [127:0] v);
        desired_round = 4'(r);
        @(negedge clk);
        v = expanded_key;
    endtask

    // returns at the negedge right after the accepting edge
    task automatic pulse_start(input logic [127:0] fk);
        @(negedge clk);
        start = 1;
        final_key = fk;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int n0, input string name);
        int n = n0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(n), 128'd10);
    endtask

    task automatic check_all(input string name);
        logic [127:0] v;
        for (int r = 0; r < 11; r++) begin
            read(r, v);
            check($sformatf("%s r%0d", name, r), v, model_k[r]);
        end
    endtask

    initial begin
        logic [127:0] v, last_fk, fk;
        tests = 0;
        fails = 0;
        reset = 0;
        start = 0;
        final_key = '0;
        desired_round = 0;
        vecs[0] = '{V1, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{V1, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[2] = '{V1, 9,  128'h549932d1f08557681093ed9cbe2c974e};
        vecs[3] = '{V1, 10, V1};
        vecs[4] = '{V2, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        #12;
        check("reset busy", 128'(busy), 0);
        check("reset done", 128'(done), 0);
        check("reset key", expanded_key, 0);
        @(negedge clk);
        reset = 1;

        last_fk = '0;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].fk !== last_fk) begin
                pulse_start(vecs[i].fk);
                check("busy after accept", 128'(busy), 1);
                wait_done(0, "done latency");
                last_fk = vecs[i].fk;
            end
            read(vecs[i].rnd, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        for (int t = 0; t < 4; t++) begin
            fk = {$urandom, $urandom, $urandom, $urandom};
            model(fk);
            pulse_start(fk);
            wait_done(0, "rand latency");
            check_all($sformatf("rand%0d", t));
        end
        for (int r = 11; r < 16; r++) begin
            read(r, v);
            check($sformatf("oob r%0d", r), v, 0);
        end

        model(V1);
        pulse_start(V1);
        repeat (3) @(negedge clk);
        start = 1;
        final_key = V2;
        @(negedge clk);
        start = 0;
        final_key = '0;
        check("busy after ignored start", 128'(busy), 1);
        wait_done(4, "ignored start latency");
        check_all("ignored start");

        model(V2);
        pulse_start(V2);
        check("done drops on restart", 128'(done), 0);
        wait_done(0, "b2b latency");
        check_all("b2b");
        read(12, v);
        check("b2b r12", v, 0);

        pulse_start(V1);
        repeat (4) @(negedge clk);
        #2 reset = 0;
        #1;
        check("abort busy", 128'(busy), 0);
        check("abort done", 128'(done), 0);
        for (int r = 0; r < 11; r++) begin
            read(r, v);
            check($sformatf("abort r%0d", r), v, 0);
        end
        reset = 1;
        model(V1);
        pulse_start(V1);
        wait_done(0, "after abort latency");
        check_all("after abort");

`ifdef INV_KEY_REG_OUT_EN
        read(10, v);
        desired_round = 0;
        #1 check("regout latency", expanded_key, model_k[10]);
        for (int r = 1; r <= 11; r++) begin
            @(negedge clk);
            check($sformatf("regout step %0d", r - 1), expanded_key, model_k[r-1]);
            desired_round = 4'(r % 11);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_key_expansion.md
Name: inv_key_expansion

Overview:
- AES-128 inverse key schedule. It takes the last round key (round 10) and walks the schedule backwards, one round per clock, down to the cipher key (round 0).
- All 11 round keys are held in an internal bank and read out by round index, in the same way as the forward expander.
- It feeds the decryption datapath, which consumes round keys 10..0 and may hold only the final round key after encryption or key-load.

Parameters:
- NR, 10, number of AES rounds. Fixed at 10 for AES-128; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request to begin inverse expansion. Sampled only when not busy.
- final_key  input  128  round-10 key. Byte 0 is at [127:120]; word w40 is [127:96].
- desired_round  input  4  read index, 0..10.
- expanded_key  output  128  round key selected by desired_round.
- busy  output  1  high while the backward walk is in progress.
- done  output  1  high once all 11 keys are valid; held until the next accepted start or reset.

Behaviour:
- Reset (reset=0, asynchronous): bank[0..10] cleared to 0, round counter = 0, busy = 0, done = 0, FSM = IDLE. Reset mid-walk aborts the walk; the bank is left zeroed.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 at edge E0: bank[10] <= final_key; cur <= final_key; cnt <= 10; busy <= 1; done <= 0; go to RUN.
  - RUN, edges E1..E10: compute prev from cur and Rcon[cnt]; bank[cnt-1] <= prev; cur <= prev; cnt <= cnt-1.
  - At E10 (cnt goes 1 -> 0): busy <= 0, done <= 1, go to DONE.
  - Latency: done is first high after the 10th rising edge following the accepting edge.
- start while busy: ignored. The walk continues unchanged.
- start in DONE: accepted. done drops at the accepting edge, and bank entries are overwritten as the walk proceeds.
- final_key is sampled only at E0; later changes have no effect.
- Inverse step, with cur = {w0,w1,w2,w3} and prev = {p0,p1,p2,p3}:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[cnt],24'h0}
  - RotWord rotates left by one byte.
  - SubWord uses the forward AES S-box on 4 bytes (not the inverse S-box).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Read port: expanded_key = bank[desired_round], combinational.
  - desired_round 11..15 returns 128'h0.
  - Reads during RUN return whatever is currently stored; values are valid for all indices only while done=1.

Optional Feature:
- Macro: INV_KEY_REG_OUT_EN.
- Defined: expanded_key is registered, giving a one-cycle read latency (desired_round at edge N appears after edge N+1). The register resets to 0.
- Undefined: combinational read with zero latency, as above.

Test Plan:
- Cipher key 000102030405060708090a0b0c0d0e0f:
  - final_key = 13111d7fe3944a17f307a78b4d2b30c5, pulse start.
  - done is high exactly 10 edges after acceptance.
  - round 0 = 000102030405060708090a0b0c0d0e0f
  - round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe
  - round 9 = 549932d1f08557681093ed9cbe2c974e
  - round 10 = final_key
- FIPS-197 App. A: final_key = d014f9a8c9ee2589e13f0cc8b6630ca6 -> round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
- start re-pulsed at cycle 4 of a walk with a different final_key -> ignored; results match the first final_key; done timing unchanged.
- reset driven low at cycle 5 of a walk -> busy=0, done=0 immediately. All rounds read 0. A fresh start then completes normally.
- Back-to-back: start in DONE with the second vector -> done drops at the accepting edge, returns after 10 edges, and the bank holds the second schedule. desired_round=12 -> expanded_key = 0.
- With INV_KEY_REG_OUT_EN defined: step desired_round 0..10 once per clock -> each key appears one cycle after its index.
